register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the data/register width.
REQ-002 SHALL have parameter PC_RESET, default 0, giving the program counter value after reset.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  instruction-step enable; state updates only when high.
REQ-006 SHALL have port sum  input  WIDTH  adder result to write back.
REQ-007 SHALL have port co  input  1  adder carry-out for the current instruction.
REQ-008 SHALL have port ld  input  4  one-hot load select: bit0 A, bit1 B, bit2 OUT, bit3 PC.
REQ-009 SHALL have port reg_a  output  WIDTH  register A.
REQ-010 SHALL have port reg_b  output  WIDTH  register B.
REQ-011 SHALL have port out_port  output  WIDTH  output-port register.
REQ-012 SHALL have port pc  output  WIDTH  program counter.
REQ-013 SHALL have port c_flag  output  1  registered carry flag.
REQ-014 SHALL have port halted  output  1  halt indicator (see Configuration).

Function
REQ-015 SHALL, on a clk edge with en=1, load sum into every register whose ld bit is set.
REQ-016 SHALL, on a clk edge with en=1 and ld[3]=0, increment pc by 1 modulo 2^WIDTH (15 -> 0 for WIDTH=4).
REQ-017 SHALL, on a clk edge with en=1 and ld[3]=1, load pc from sum with no increment.
REQ-018 SHALL latch co into c_flag on every clk edge with en=1, regardless of ld.
REQ-019 SHALL hold all registers and c_flag unchanged on clk edges with en=0.
REQ-020 SHALL, when ld has multiple bits set, load every selected register in the same cycle; no priority, no error.
REQ-021 SHALL treat ld=4'b0000 as a no-op on A, B and OUT; pc still increments and c_flag still latches.
REQ-022 SHALL have a write-to-output latency of one clk edge; outputs are registers with no combinational path from inputs.

Reset
REQ-023 SHALL, while reset=1 at a clk edge, set reg_a=0, reg_b=0, out_port=0, pc=PC_RESET, c_flag=0 and halted=0, independent of en and ld.
REQ-024 SHALL give reset priority over every other update, including one arriving mid-step with en=1.

Configuration
REQ-025 SHALL, with macro REGISTER_FILE_HALT_EN defined, set halted to 1 on an enabled edge where ld[3]=1 and sum equals current pc (jump-to-self).
REQ-026 SHALL, with REGISTER_FILE_HALT_EN defined and halted=1, block all register and c_flag updates until reset.
REQ-027 SHALL, without REGISTER_FILE_HALT_EN, tie halted to constant 0 and keep the jump-to-self behaviour of REQ-017.

Structure
REQ-028 SHALL take the ld bit-index constants (LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3) from shared package td4_pkg.
REQ-029 SHALL contain one sub-module, pc_counter, implementing the pc increment/load/hold behaviour.

Verification
REQ-030 SHALL cover reset: reset=1 with en=1, ld=4'b1111, sum=4'hF -> all registers 0, pc=PC_RESET, c_flag=0.
REQ-031 SHALL cover writes: en=1, ld=4'b0001, sum=4'h9, co=1 -> reg_a=9, c_flag=1, pc +1, reg_b unchanged.
REQ-032 SHALL cover wrap: pc=4'hF, en=1, ld=0 -> pc=0; and en=0 for 3 edges -> no register changes.
REQ-033 SHALL cover jump: pc=3, ld=4'b1000, sum=4'hA -> pc=A; ld=4'b0110, sum=5 -> reg_b=5, out_port=5.
REQ-034 SHALL cover halt with REGISTER_FILE_HALT_EN: pc=7, ld=4'b1000, sum=7 -> halted=1, subsequent writes ignored; reset clears it. The same stimulus without the macro -> halted stays 0 and later writes take effect.

Source files
------------

// File: rtl/td4_pkg.sv
// td4_pkg: load-select bit positions shared by the register file and its users
package td4_pkg;
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;
  localparam int LD_W   = 4;
endpackage

// File: rtl/register_file_pc_counter.sv
// pc_counter: program counter that holds, loads a jump target or increments with wrap
module pc_counter #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_pc;
  // reset wins; otherwise a step either jumps to d or advances by one, modulo 2^WIDTH
  always_ff @(posedge clk)
    r_pc <= reset ? PC_RESET : !en ? r_pc : load ? d : r_pc + 1'b1;
  assign q = r_pc;
endmodule

// File: rtl/register_file.sv
// register_file: A/B/OUT/PC registers and carry flag of a TD4-style CPU; optional halt on jump-to-self via REGISTER_FILE_HALT_EN
module register_file
  import td4_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] sum,
  input  logic             co,
  input  logic [LD_W-1:0]  ld,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] pc,
  output logic             c_flag,
  output logic             halted
);
  logic [WIDTH-1:0] r_a, r_b, r_out, w_pc;
  logic             r_c, w_halted, w_step;
`ifdef REGISTER_FILE_HALT_EN
  logic r_halted;
  logic w_jump_self;
  assign w_jump_self = ld[LD_PC] && (sum == w_pc);
  // a jump to the current pc parks the machine until the next reset
  always_ff @(posedge clk)
    r_halted <= reset ? 1'b0 : r_halted | (en & w_jump_self);
  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif
  assign w_step = en & ~w_halted;
  // write the adder result into each selected register and capture the carry every step
  always_ff @(posedge clk)
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_out <= '0;
      r_c   <= 1'b0;
    end else if (w_step) begin
      if (ld[LD_A])   r_a   <= sum;
      if (ld[LD_B])   r_b   <= sum;
      if (ld[LD_OUT]) r_out <= sum;
      r_c <= co;
    end
  pc_counter #(.WIDTH(WIDTH), .PC_RESET(PC_RESET)) u_pc (
    .clk  (clk),
    .reset(reset),
    .en   (w_step),
    .load (ld[LD_PC]),
    .d    (sum),
    .q    (w_pc)
  );
  assign reg_a    = r_a;
  assign reg_b    = r_b;
  assign out_port = r_out;
  assign pc       = w_pc;
  assign c_flag   = r_c;
  assign halted   = w_halted;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file writes, pc wrap/jump, hold, reset and halt (REGISTER_FILE_HALT_EN aware)
module tb_register_file;
  logic       clk = 1'b0;
  logic       reset, en, co;
  logic [3:0] sum, ld;
  logic [3:0] reg_a, reg_b, out_port, pc;
  logic       c_flag, halted;
  int         vectors = 0;
  int         miscompares = 0;

  register_file dut (
    .clk(clk), .reset(reset), .en(en), .sum(sum), .co(co), .ld(ld),
    .reg_a(reg_a), .reg_b(reg_b), .out_port(out_port), .pc(pc),
    .c_flag(c_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [3:0] l, input logic [3:0] s, input logic c);
    reset = r; en = e; ld = l; sum = s; co = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 4'b1111, 4'hF, 1'b1);
    vectors++; if (reg_a !== 4'h0) begin miscompares++; $display("FAIL reset_a: got %h want %h", reg_a, 4'h0); end
    vectors++; if (reg_b !== 4'h0) begin miscompares++; $display("FAIL reset_b: got %h want %h", reg_b, 4'h0); end
    vectors++; if (out_port !== 4'h0) begin miscompares++; $display("FAIL reset_out: got %h want %h", out_port, 4'h0); end
    vectors++; if (pc !== 4'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 4'h0); end
    vectors++; if (c_flag !== 1'b0) begin miscompares++; $display("FAIL reset_c: got %b want %b", c_flag, 1'b0); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want %b", halted, 1'b0); end
  endtask

  task automatic test_write();
    step(1'b0, 1'b1, 4'b0001, 4'h9, 1'b1);
    vectors++; if (reg_a !== 4'h9) begin miscompares++; $display("FAIL write_a: got %h want %h", reg_a, 4'h9); end
    vectors++; if (c_flag !== 1'b1) begin miscompares++; $display("FAIL write_c: got %b want %b", c_flag, 1'b1); end
    vectors++; if (pc !== 4'h1) begin miscompares++; $display("FAIL write_pc: got %h want %h", pc, 4'h1); end
    vectors++; if (reg_b !== 4'h0) begin miscompares++; $display("FAIL write_b: got %h want %h", reg_b, 4'h0); end
  endtask

  task automatic test_jump();
    step(1'b0, 1'b1, 4'b0000, 4'h7, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 4'h7, 1'b0);
    vectors++; if (pc !== 4'h3) begin miscompares++; $display("FAIL noop_pc: got %h want %h", pc, 4'h3); end
    vectors++; if (c_flag !== 1'b0) begin miscompares++; $display("FAIL noop_c: got %b want %b", c_flag, 1'b0); end
    vectors++; if (reg_a !== 4'h9) begin miscompares++; $display("FAIL noop_a: got %h want %h", reg_a, 4'h9); end
    step(1'b0, 1'b1, 4'b1000, 4'hA, 1'b0);
    vectors++; if (pc !== 4'hA) begin miscompares++; $display("FAIL jump_pc: got %h want %h", pc, 4'hA); end
    vectors++; if (reg_a !== 4'h9) begin miscompares++; $display("FAIL jump_a: got %h want %h", reg_a, 4'h9); end
    step(1'b0, 1'b1, 4'b0110, 4'h5, 1'b1);
    vectors++; if (reg_b !== 4'h5) begin miscompares++; $display("FAIL multi_b: got %h want %h", reg_b, 4'h5); end
    vectors++; if (out_port !== 4'h5) begin miscompares++; $display("FAIL multi_out: got %h want %h", out_port, 4'h5); end
    vectors++; if (reg_a !== 4'h9) begin miscompares++; $display("FAIL multi_a: got %h want %h", reg_a, 4'h9); end
    vectors++; if (pc !== 4'hB) begin miscompares++; $display("FAIL multi_pc: got %h want %h", pc, 4'hB); end
    vectors++; if (c_flag !== 1'b1) begin miscompares++; $display("FAIL multi_c: got %b want %b", c_flag, 1'b1); end
  endtask

  task automatic test_wrap_hold();
    step(1'b0, 1'b1, 4'b1000, 4'hF, 1'b1);
    vectors++; if (pc !== 4'hF) begin miscompares++; $display("FAIL to_f_pc: got %h want %h", pc, 4'hF); end
    step(1'b0, 1'b1, 4'b0000, 4'h2, 1'b0);
    vectors++; if (pc !== 4'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want %h", pc, 4'h0); end
    vectors++; if (c_flag !== 1'b0) begin miscompares++; $display("FAIL wrap_c: got %b want %b", c_flag, 1'b0); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1111, 4'h3, 1'b1);
    vectors++; if (reg_a !== 4'h9) begin miscompares++; $display("FAIL hold_a: got %h want %h", reg_a, 4'h9); end
    vectors++; if (reg_b !== 4'h5) begin miscompares++; $display("FAIL hold_b: got %h want %h", reg_b, 4'h5); end
    vectors++; if (out_port !== 4'h5) begin miscompares++; $display("FAIL hold_out: got %h want %h", out_port, 4'h5); end
    vectors++; if (pc !== 4'h0) begin miscompares++; $display("FAIL hold_pc: got %h want %h", pc, 4'h0); end
    vectors++; if (c_flag !== 1'b0) begin miscompares++; $display("FAIL hold_c: got %b want %b", c_flag, 1'b0); end
  endtask

  task automatic test_halt();
    logic       exp_h;
    logic [3:0] exp_r, exp_pc;
    logic       exp_c;
`ifdef REGISTER_FILE_HALT_EN
    exp_h = 1'b1; exp_r = 4'h0; exp_pc = 4'h7; exp_c = 1'b0;
`else
    exp_h = 1'b0; exp_r = 4'hC; exp_pc = 4'h8; exp_c = 1'b1;
`endif
    step(1'b1, 1'b0, 4'b0000, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 4'h7, 1'b0);
    vectors++; if (pc !== 4'h7) begin miscompares++; $display("FAIL pre_halt_pc: got %h want %h", pc, 4'h7); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL pre_halt_h: got %b want %b", halted, 1'b0); end
    step(1'b0, 1'b1, 4'b1000, 4'h7, 1'b0);
    vectors++; if (halted !== exp_h) begin miscompares++; $display("FAIL halt_h: got %b want %b", halted, exp_h); end
    vectors++; if (pc !== 4'h7) begin miscompares++; $display("FAIL halt_pc: got %h want %h", pc, 4'h7); end
    step(1'b0, 1'b1, 4'b0111, 4'hC, 1'b1);
    vectors++; if (reg_a !== exp_r) begin miscompares++; $display("FAIL after_a: got %h want %h", reg_a, exp_r); end
    vectors++; if (reg_b !== exp_r) begin miscompares++; $display("FAIL after_b: got %h want %h", reg_b, exp_r); end
    vectors++; if (out_port !== exp_r) begin miscompares++; $display("FAIL after_out: got %h want %h", out_port, exp_r); end
    vectors++; if (pc !== exp_pc) begin miscompares++; $display("FAIL after_pc: got %h want %h", pc, exp_pc); end
    vectors++; if (c_flag !== exp_c) begin miscompares++; $display("FAIL after_c: got %b want %b", c_flag, exp_c); end
    vectors++; if (halted !== exp_h) begin miscompares++; $display("FAIL after_h: got %b want %b", halted, exp_h); end
    step(1'b1, 1'b1, 4'b1111, 4'h0, 1'b1);
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL clear_h: got %b want %b", halted, 1'b0); end
    vectors++; if (pc !== 4'h0) begin miscompares++; $display("FAIL clear_pc: got %h want %h", pc, 4'h0); end
    step(1'b0, 1'b1, 4'b0001, 4'h6, 1'b0);
    vectors++; if (reg_a !== 4'h6) begin miscompares++; $display("FAIL resume_a: got %h want %h", reg_a, 4'h6); end
    vectors++; if (pc !== 4'h1) begin miscompares++; $display("FAIL resume_pc: got %h want %h", pc, 4'h1); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; ld = '0; sum = '0; co = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_jump();
    test_wrap_hold();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
